signed_seq_divider: RTL and testbench
=====================================

# signed_seq_divider

Sequential 16-bit signed restoring divider in the ALU_16 datapath, directly downstream of `operands_negator`. It consumes the raw operands plus the negator's packed `{-op1, -op2}` word and selects operand magnitudes from it instead of negating internally. It then runs a 16-iteration restoring division and applies sign correction to produce quotient and remainder. It also rejects MIN_INT_16 (16'h8000) operands, which the negator does not support.

## Interface
- `WIDTH`, default 16: operand width. Only 16 is supported, because the packed negator word is 2×WIDTH.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op1`  in  16  signed dividend.
- `op2`  in  16  signed divisor.
- `neg_ops`  in  32  negator output: [31:16] = -op1, [15:0] = -op2. Must correspond to the current `op1`/`op2` whenever `start` is sampled.
- `busy`  out  1  high in DIV and FIX states.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  16  signed quotient, truncated toward zero.
- `remainder`  out  16  signed remainder; sign follows the dividend.
- `err`  out  1  error flag; valid while `done`=1 and held until the next accepted `start`.

## Operation
- States: IDLE, DIV, FIX, DONE.
- **IDLE/DONE + `start`=1**
  - Latch the operand signs and error conditions. Clear the partial remainder.
  - Magnitude A = `op1[15]` ? `neg_ops[31:16]` : `op1`.
  - Magnitude B = `op2[15]` ? `neg_ops[15:0]` : `op2`.
- **Error check at accept**
  - If `op1` or `op2` is 16'h8000: go directly to DONE, set `err`=1, `quotient`=0, `remainder`=0.
- **DIV (16 iterations, MSB first)**
  - rem' = {rem[14:0], A[msb]}.
  - If rem' ≥ B: rem = rem' − B and the quotient bit is 1.
  - Otherwise: rem = rem' and the quotient bit is 0.
  - The internal remainder is 17 bits wide, so the compare has no overflow.
- **FIX (one cycle)**
  - Negate the quotient magnitude if `op1[15]` ^ `op2[15]`.
  - Negate the remainder magnitude if `op1[15]`.
- **DONE (one cycle)**
  - `done`=1 and `err`=0.
  - Then go to IDLE, or back to DIV if a new `start` is accepted.
- `quotient`, `remainder` and `err` update only on entry to DONE and hold until the next DONE entry.
- `start` while `busy`=1 is ignored: no queuing and no effect on the running operation.

## Timing
- Reset: state=IDLE; `busy`, `done`, `err`=0; `quotient`, `remainder`=16'h0000.
- Reset asserted mid-operation aborts at the next edge with the same reset values; no `done` pulse follows.
- Normal latency, with `start` accepted at edge E0:
  - DIV runs on edges E1–E16.
  - FIX executes at E17.
  - `done`=1 in the cycle after E17, i.e. 17 cycles after acceptance.
- Error latency: `done`=1 in the cycle immediately after E0.
- `busy` rises the cycle after E0 and falls together with `done` rising.
- Back-to-back: `start` held high during a DONE cycle is accepted. The next `done` then follows 17 cycles later, giving a throughput of one division per 18 cycles.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - `op2`=0 at accept takes the error path: direct to DONE after 1 cycle.
  - Outputs: `err`=1, `quotient`=0, `remainder`=`op1`.
- Not defined:
  - No zero check; the division runs the full 17 cycles.
  - Result: `quotient` = `op1`<0 ? 16'h0001 : 16'hFFFF, `remainder` = `op1`, `err`=0.
  - The MIN_INT check is always present.

## Test plan
- 100 / 7, `neg_ops`={-100, -7} → `done` 17 cycles after `start`; `quotient`=14, `remainder`=2, `err`=0.
- −100 / 7 → `quotient`=−14, `remainder`=−2. Separately, 100 / −7 → `quotient`=−14, `remainder`=2.
- `op1`=16'h8000, `op2`=3 → `done` 1 cycle after `start`; `err`=1, `quotient`=0, `remainder`=0.
- `op1`=50, `op2`=0:
  - With `DIV_ZERO_CHECK_EN`: `done` after 1 cycle; `err`=1, `remainder`=50.
  - Without it: `done` after 17 cycles; `quotient`=16'hFFFF, `remainder`=50.
- Pulse `start` with 9/2 at cycle 5 of a running 100/7 → ignored. The running operation returns 14 and 2 on schedule.
- Assert `rst_n`=0 for 1 cycle at DIV iteration 8 → next cycle `busy`=0, outputs zero, no `done`. A fresh 100/7 afterwards completes normally.

Source files
------------

// File: rtl/signed_seq_divider.sv
// Sequential signed restoring divider: one quotient bit per cycle, sign fix-up in a final cycle.
// Optional `DIV_ZERO_CHECK_EN` turns a zero divisor into an immediate error completion.
`timescale 1ns/1ps
module signed_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2*WIDTH-1:0]   neg_ops,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first; quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  // The shifted partial remainder is one bit wider than the divisor so the compare cannot wrap.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sign1_d = op1[WIDTH-1];
          sign2_d = op2[WIDTH-1];
          dvd_d   = op1[WIDTH-1] ? neg_ops[2*WIDTH-1:WIDTH] : op1;
          dvs_d   = op2[WIDTH-1] ? neg_ops[WIDTH-1:0]       : op2;
          rem_d   = '0;
          cnt_d   = '0;
          if ((op1 == MIN_INT) || (op2 == MIN_INT)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            quo_d   = '0;
            rmd_d   = '0;
          end
`ifdef DIV_ZERO_CHECK_EN
          else if (op2 == '0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            quo_d   = '0;
            rmd_d   = op1;
          end
`endif
          else begin
            state_d = S_DIV;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        // The result is below the divisor, so the narrow subtract is exact.
        if (rem_ge) begin
          rem_d = rem_shift[WIDTH-1:0] - dvs_q;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        quo_d   = (sign1_q ^ sign2_q) ? -dvd_q : dvd_q;
        rmd_d   = sign1_q ? -rem_q : rem_q;
        err_d   = 1'b0;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only control state and visible results are reset; the datapath is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    rem_q   <= rem_d;
    sign1_q <= sign1_d;
    sign2_q <= sign2_d;
  end

  assign busy      = (state_q == S_DIV) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign err       = err_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: directed cases plus random operands vs. an arithmetic model.
// Honours `DIV_ZERO_CHECK_EN` the same way the design does.
`timescale 1ns/1ps
module tb_signed_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] op1, op2;
  logic [31:0] neg_ops;
  logic        busy, done, err;
  logic [15:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  signed_seq_divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op1       (op1),
    .op2       (op2),
    .neg_ops   (neg_ops),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: truncating signed division; latency counted in edges after the accepting edge.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic e, output int lat);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (a == 16'h8000 || b == 16'h8000) begin
      q = 16'h0; r = 16'h0; e = 1'b1; lat = 0;
    end else if (b == 16'h0) begin
`ifdef DIV_ZERO_CHECK_EN
      q = 16'h0; r = a; e = 1'b1; lat = 0;
`else
      q = (sa < 0) ? 16'h0001 : 16'hFFFF; r = a; e = 1'b0; lat = 17;
`endif
    end else begin
      q = 16'(sa / sb); r = 16'(sa % sb); e = 1'b0; lat = 17;
    end
  endtask

  task automatic drive_ops(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] na, nb;
    na = -a;
    nb = -b;
    op1 = a;
    op2 = b;
    neg_ops = {na, nb};
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    drive_ops(a, b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b, input int lat);
    logic [15:0] eq, er;
    logic        ee;
    int          elat;
    model(a, b, eq, er, ee, elat);
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".q"},   {16'h0, quotient},  {16'h0, eq});
    check({tag, ".r"},   {16'h0, remainder}, {16'h0, er});
    check({tag, ".err"}, {31'h0, err},       {31'h0, ee});
    check({tag, ".busy"}, {31'h0, busy},     32'h0);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    launch(a, b);
    wait_done(0, lat);
    check_result(tag, a, b, lat);
  endtask

  initial begin
    int lat, done_seen;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    drive_ops(16'h0, 16'h0);
    repeat (3) tick();
    check("rst.busy", {31'h0, busy}, 32'h0);
    check("rst.done", {31'h0, done}, 32'h0);
    check("rst.err",  {31'h0, err},  32'h0);
    check("rst.q",    {16'h0, quotient},  32'h0);
    check("rst.r",    {16'h0, remainder}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Directed sign cases; busy must be up the cycle after accept.
    launch(16'd100, 16'd7);
    check("p100_7.busy_rise", {31'h0, busy}, 32'h1);
    wait_done(0, lat);
    check_result("p100_7", 16'd100, 16'd7, lat);
    check("p100_7.q_const", {16'h0, quotient}, 32'd14);
    check("p100_7.r_const", {16'h0, remainder}, 32'd2);
    tick();
    run_div("m100_7", 16'hFF9C, 16'd7);
    check("m100_7.q_const", {16'h0, quotient}, 32'h0000FFF2);
    check("m100_7.r_const", {16'h0, remainder}, 32'h0000FFFE);
    run_div("p100_m7", 16'd100, 16'hFFF9);
    check("p100_m7.q_const", {16'h0, quotient}, 32'h0000FFF2);
    check("p100_m7.r_const", {16'h0, remainder}, 32'h00000002);
    run_div("m100_m7", 16'hFF9C, 16'hFFF9);

    // MIN_INT rejection, then err must hold while idle.
    tick();
    run_div("minint_op1", 16'h8000, 16'd3);
    repeat (3) tick();
    check("minint.err_hold",  {31'h0, err},  32'h1);
    check("minint.done_low",  {31'h0, done}, 32'h0);
    run_div("minint_op2", 16'd5, 16'h8000);

    // Divide by zero, both signs of dividend.
    run_div("zero_p50", 16'd50, 16'h0);
    run_div("zero_m50", 16'hFFCE, 16'h0);

    // Boundary magnitudes.
    run_div("max_div_1",   16'h7FFF, 16'd1);
    run_div("min1_div_m1", 16'h8001, 16'hFFFF);
    run_div("small_big",   16'd3, 16'h7FFF);
    run_div("exact",       16'hFF00, 16'h0010);

    // A start pulse while busy must not disturb the running division.
    tick();
    launch(16'd100, 16'd7);
    repeat (4) tick();
    drive_ops(16'd9, 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_ops(16'd100, 16'd7);
    wait_done(5, lat);
    check_result("ignore_start", 16'd100, 16'd7, lat);

    // Reset in the middle of the division aborts with no done.
    tick();
    launch(16'd100, 16'd7);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.busy", {31'h0, busy}, 32'h0);
    check("midrst.done", {31'h0, done}, 32'h0);
    check("midrst.q",    {16'h0, quotient},  32'h0);
    check("midrst.r",    {16'h0, remainder}, 32'h0);
    check("midrst.err",  {31'h0, err},       32'h0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("midrst.no_done", 32'(done_seen), 32'h0);
    run_div("after_rst", 16'd100, 16'd7);

    // Random operands, mostly back-to-back, sometimes with an idle gap.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) begin
        rb = 16'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end
      if (i % 8 == 5) rb = 16'h0;
      if (i % 11 == 7) ra = 16'h8000;
      if (i % 4 == 2) tick();
      run_div($sformatf("rnd%0d", i), ra, rb);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
